mcs4_bus_sequencer: RTL and testbench

- Passive bus-cycle controller for the MCS-4 system bus, clocked by sysclk.
- Samples the 2-phase clocks, sync, CM lines and the 4-bit data bus, and tracks the 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3).
- Publishes phase strobes, the fetched 12-bit address, the opcode, I/O and SRC command decodes, and two-word-instruction tracking.
- Drives the sequencing of the i4001/i4002 peripheral models and bus monitors from one shared place.

---
 rtl/mcs4_pkg.sv | 48 ++++
 rtl/mcs4_clk_edge.sv | 19 +
 rtl/mcs4_bus_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mcs4_bus_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus definitions: subcycle state encoding, phase bit indices,
// opcode constants and instruction-length decode helpers.
package mcs4_pkg;

  // Each locked state's code is one above its phase bit index.
  typedef enum logic [3:0] {
    ST_UNSYNC = 4'd0,
    ST_A1     = 4'd1,
    ST_A2     = 4'd2,
    ST_A3     = 4'd3,
    ST_M1     = 4'd4,
    ST_M2     = 4'd5,
    ST_X1     = 4'd6,
    ST_X2     = 4'd7,
    ST_X3     = 4'd8
  } state_t;

  localparam int PH_A1 = 0;
  localparam int PH_A2 = 1;
  localparam int PH_A3 = 2;
  localparam int PH_M1 = 3;
  localparam int PH_M2 = 4;
  localparam int PH_X1 = 5;
  localparam int PH_X2 = 6;
  localparam int PH_X3 = 7;

  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;

  function automatic logic is_two_word(input logic [7:0] op);
    logic result;
    result = 1'b0;
    case (op[7:4])
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: result = 1'b1;
      OPR_FIM_SRC:                         result = ~op[0];
      default:                             result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic is_src(input logic [7:0] op);
    return (op[7:4] == OPR_FIM_SRC) && op[0];
  endfunction

endpackage

// File: rtl/mcs4_clk_edge.sv
// Phase-2 falling-edge detector: one-sysclk event marking each bus subcycle boundary.
module mcs4_clk_edge (
  input  logic sysclk,
  input  logic poc_pad,
  input  logic clk2,
  output logic ev
);

  logic clk2_q;

  // clk2_q clears on reset, so the edge after poc_pad release can never fire ev.
  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) clk2_q <= 1'b0;
    else         clk2_q <= clk2;
  end

  assign ev = clk2_q & ~clk2;

endmodule

// File: rtl/mcs4_bus_sequencer.sv
// Passive MCS-4 instruction-cycle tracker (A1..X3) with fetch, I/O and SRC decode.
// Optional statistics counters are enabled by defining MCS4_BUS_SEQ_STATS_EN.
module mcs4_bus_sequencer
  import mcs4_pkg::*;
#(
  parameter logic [3:0] SYNC_TIMEOUT = 4'd8
) (
  input  logic        sysclk,
  input  logic        poc_pad,
  input  logic        clk1,
  input  logic        clk2,
  input  logic        sync,
  input  logic        cmrom,
  input  logic [3:0]  cmram,
  input  logic [3:0]  data_in,
  output logic [7:0]  phase,
  output logic        locked,
  output logic        step,
  output logic [11:0] addr,
  output logic        addr_valid,
  output logic [7:0]  opcode,
  output logic        opcode_valid,
  output logic        second_word,
  output logic        io_cycle,
  output logic        src_valid,
  output logic [7:0]  src_addr,
  output logic [3:0]  src_bank,
  output logic        sync_err
`ifdef MCS4_BUS_SEQ_STATS_EN
  ,
  output logic [15:0] cycle_count,
  output logic [7:0]  err_count
`endif
);

  logic       ev;
  state_t     state_reg, state_next;
  logic [3:0] sync_cnt_reg;
  logic       pending_reg, src_cand_reg, src_arm_reg;
  logic       enter_a1, seq_err, cap_ok, drop, timeout_hit, cm_any, err_pulse;
  logic [7:0] op_full;

  mcs4_clk_edge u_clk_edge (
    .sysclk  (sysclk),
    .poc_pad (poc_pad),
    .clk2    (clk2),
    .ev      (ev)
  );

  assign locked      = (state_reg != ST_UNSYNC);
  assign cm_any      = cmrom | (|cmram);
  assign op_full     = {opcode[7:4], data_in};
  assign timeout_hit = ({1'b0, sync_cnt_reg} + 5'd1) >= {1'b0, SYNC_TIMEOUT};
  assign drop        = ev && locked && (state_next == ST_UNSYNC);
  // Overlapping clocks at the boundary make the sync sample untrustworthy.
  assign err_pulse   = seq_err & ~clk1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_phase
    assign phase[gi] = (state_reg == state_t'(4'(gi + 1)));
  end

  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) state_reg <= ST_UNSYNC;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    enter_a1   = 1'b0;
    seq_err    = 1'b0;
    cap_ok     = 1'b0;
    if (ev) begin
      if (!locked) begin
        if (sync) begin
          state_next = ST_A1;
          enter_a1   = 1'b1;
        end
      end else if (sync) begin
        state_next = ST_A1;
        enter_a1   = 1'b1;
        if (state_reg == ST_X3) cap_ok  = 1'b1;
        else                    seq_err = 1'b1;
      end else begin
        cap_ok = 1'b1;
        if (state_reg == ST_X3 || timeout_hit) begin
          state_next = ST_UNSYNC;
          seq_err    = 1'b1;
        end else begin
          state_next = state_t'(state_reg + 4'd1);
        end
      end
    end
  end

  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      sync_cnt_reg <= 4'd0;
      pending_reg  <= 1'b0;
      src_cand_reg <= 1'b0;
      src_arm_reg  <= 1'b0;
      step         <= 1'b0;
      addr         <= 12'd0;
      addr_valid   <= 1'b0;
      opcode       <= 8'd0;
      opcode_valid <= 1'b0;
      second_word  <= 1'b0;
      io_cycle     <= 1'b0;
      src_valid    <= 1'b0;
      src_addr     <= 8'd0;
      src_bank     <= 4'd0;
      sync_err     <= 1'b0;
    end else begin
      step         <= ev && (locked || sync);
      sync_err     <= err_pulse;
      addr_valid   <= 1'b0;
      opcode_valid <= 1'b0;
      src_valid    <= 1'b0;

      if (ev) begin
        if (sync || state_next == ST_UNSYNC) sync_cnt_reg <= 4'd0;
        else                                 sync_cnt_reg <= sync_cnt_reg + 4'd1;
      end

      if (enter_a1) begin
        second_word  <= pending_reg;
        pending_reg  <= 1'b0;
        io_cycle     <= 1'b0;
        src_cand_reg <= 1'b0;
        src_arm_reg  <= 1'b0;
      end

      // Losing lock abandons any in-flight instruction context.
      if (drop) begin
        second_word  <= 1'b0;
        pending_reg  <= 1'b0;
        io_cycle     <= 1'b0;
        src_cand_reg <= 1'b0;
        src_arm_reg  <= 1'b0;
      end

      if (cap_ok) begin
        case (state_reg)
          ST_A1: addr[3:0]  <= data_in;
          ST_A2: addr[7:4]  <= data_in;
          ST_A3: begin
            addr[11:8] <= data_in;
            addr_valid <= 1'b1;
          end
          ST_M1: opcode[7:4] <= data_in;
          ST_M2: begin
            opcode[3:0]  <= data_in;
            opcode_valid <= 1'b1;
            pending_reg  <= is_two_word(op_full) && !second_word;
            io_cycle     <= cm_any && !second_word;
            src_cand_reg <= is_src(op_full) && !second_word;
          end
          ST_X2: begin
            if (src_cand_reg && cm_any) begin
              src_bank      <= cmram;
              src_addr[7:4] <= data_in;
              src_arm_reg   <= 1'b1;
            end
          end
          ST_X3: begin
            if (src_arm_reg) begin
              src_addr[3:0] <= data_in;
              src_valid     <= 1'b1;
            end
            src_arm_reg <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MCS4_BUS_SEQ_STATS_EN
  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      cycle_count <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      if (enter_a1) cycle_count <= cycle_count + 16'd1;
      if (err_pulse && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mcs4_bus_sequencer.sv
// Directed bench for mcs4_bus_sequencer: drives 2-phase clocks and bus nibbles per subcycle.
module tb_mcs4_bus_sequencer;

  logic        sysclk = 1'b0;
  logic        poc_pad = 1'b1;
  logic        clk1 = 1'b0;
  logic        clk2 = 1'b0;
  logic        sync = 1'b0;
  logic        cmrom = 1'b0;
  logic [3:0]  cmram = 4'd0;
  logic [3:0]  data_in = 4'd0;
  logic [7:0]  phase;
  logic        locked, step, addr_valid, opcode_valid, second_word, io_cycle;
  logic        src_valid, sync_err;
  logic [11:0] addr;
  logic [7:0]  opcode, src_addr;
  logic [3:0]  src_bank;
`ifdef MCS4_BUS_SEQ_STATS_EN
  logic [15:0] cycle_count;
  logic [7:0]  err_count;
`endif

  mcs4_bus_sequencer dut (
    .sysclk       (sysclk),
    .poc_pad      (poc_pad),
    .clk1         (clk1),
    .clk2         (clk2),
    .sync         (sync),
    .cmrom        (cmrom),
    .cmram        (cmram),
    .data_in      (data_in),
    .phase        (phase),
    .locked       (locked),
    .step         (step),
    .addr         (addr),
    .addr_valid   (addr_valid),
    .opcode       (opcode),
    .opcode_valid (opcode_valid),
    .second_word  (second_word),
    .io_cycle     (io_cycle),
    .src_valid    (src_valid),
    .src_addr     (src_addr),
    .src_bank     (src_bank),
    .sync_err     (sync_err)
`ifdef MCS4_BUS_SEQ_STATS_EN
    ,
    .cycle_count  (cycle_count),
    .err_count    (err_count)
`endif
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;
  int c_step = 0, c_av = 0, c_ov = 0, c_sv = 0, c_se = 0;
  int b_step, b_av, b_ov, b_sv, b_se;
  logic io_seen;

  // Pulse outputs are counted away from the active edge.
  always @(negedge sysclk) begin
    if (step)         c_step++;
    if (addr_valid)   c_av++;
    if (opcode_valid) c_ov++;
    if (src_valid)    c_sv++;
    if (sync_err)     c_se++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_step = c_step; b_av = c_av; b_ov = c_ov; b_sv = c_sv; b_se = c_se;
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // One subcycle: clk1 pulse, clk2 pulse, then the clk2 fall that creates ev.
  task automatic subcycle(input logic s, input logic [3:0] d, input logic [3:0] cm);
    sync = s; data_in = d; cmram = cm;
    clk1 = 1'b1; tick();
    clk1 = 1'b0; clk2 = 1'b1; tick(); tick();
    clk2 = 1'b0; tick(); tick();
  endtask

  task automatic run_cycle(input string tag, input logic [11:0] a, input logic [7:0] op,
                           input logic [3:0] x2d, input logic [3:0] x3d,
                           input logic [3:0] cm_m2, input logic [3:0] cm_x2,
                           input logic next_sync);
    logic [3:0] nib [8];
    nib = '{a[3:0], a[7:4], a[11:8], op[7:4], op[3:0], 4'd0, x2d, x3d};
    for (int i = 0; i < 8; i++) begin
      logic [3:0] cm;
      cm = (i == 4) ? cm_m2 : ((i == 6) ? cm_x2 : 4'd0);
      subcycle((i == 7) ? next_sync : 1'b0, nib[i], cm);
      if (i == 4) io_seen = io_cycle;
      if (i < 7) check($sformatf("%s phase%0d", tag, i + 1), 32'(phase), 32'd1 << (i + 1));
    end
    $display("cycle %s: addr=%03h opcode=%02h second_word=%0b src_addr=%02h", tag, addr, opcode,
             second_word, src_addr);
  endtask

  initial begin
    repeat (3) tick();
    check("reset phase", 32'(phase), 32'h0);
    check("reset locked", 32'(locked), 32'h0);
    check("reset addr", 32'(addr), 32'h0);
    check("reset opcode", 32'(opcode), 32'h0);
    check("reset pulses", 32'(c_step + c_av + c_ov + c_sv + c_se), 32'h0);
    poc_pad = 1'b0;
    tick();

    subcycle(1'b1, 4'd0, 4'd0);
    check("lock locked", 32'(locked), 32'h1);
    check("lock phase", 32'(phase), 32'h01);
    check("lock step", 32'(c_step), 32'h1);

    // Two clean cycles
    for (int k = 0; k < 2; k++) begin
      snap();
      run_cycle("norm", 12'h3A5, 8'hD7, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
      check("norm addr", 32'(addr), 32'h3A5);
      check("norm opcode", 32'(opcode), 32'hD7);
      check("norm addr_valid", 32'(c_av - b_av), 32'h1);
      check("norm opcode_valid", 32'(c_ov - b_ov), 32'h1);
      check("norm step", 32'(c_step - b_step), 32'h8);
      check("norm sync_err", 32'(c_se - b_se), 32'h0);
      check("norm phase A1", 32'(phase), 32'h01);
      check("norm second_word", 32'(second_word), 32'h0);
    end

    // JUN, its second word, JUN again, its second word
    run_cycle("jun1", 12'h100, 8'h4C, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("jun sw c2", 32'(second_word), 32'h1);
    run_cycle("jun2", 12'h101, 8'h12, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("jun opcode c2", 32'(opcode), 32'h12);
    check("jun sw c3", 32'(second_word), 32'h0);
    run_cycle("jun3", 12'h102, 8'h4C, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("jun sw c4", 32'(second_word), 32'h1);
    run_cycle("jun4", 12'h103, 8'hD7, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("jun sw c5", 32'(second_word), 32'h0);

    // I/O cycle: CM at M2
    run_cycle("io", 12'h200, 8'hE0, 4'd0, 4'd0, 4'b0001, 4'd0, 1'b1);
    check("io held X1", 32'(io_seen), 32'h1);
    check("io cleared A1", 32'(io_cycle), 32'h0);

    // SRC with CM at X2, then without
    snap();
    run_cycle("src", 12'h210, 8'h21, 4'h9, 4'h6, 4'd0, 4'b0100, 1'b1);
    check("src valid", 32'(c_sv - b_sv), 32'h1);
    check("src addr", 32'(src_addr), 32'h96);
    check("src bank", 32'(src_bank), 32'h4);
    check("src no io", 32'(io_seen), 32'h0);
    snap();
    run_cycle("src_nocm", 12'h211, 8'h23, 4'h3, 4'h5, 4'd0, 4'd0, 1'b1);
    check("src nocm valid", 32'(c_sv - b_sv), 32'h0);
    check("src nocm addr", 32'(src_addr), 32'h96);

    // Sync at M1: resync to A1, no opcode_valid
    snap();
    subcycle(1'b0, 4'h1, 4'd0);
    subcycle(1'b0, 4'h2, 4'd0);
    subcycle(1'b0, 4'h3, 4'd0);
    check("resync addr", 32'(addr), 32'h321);
    subcycle(1'b1, 4'h4, 4'd0);
    check("resync phase", 32'(phase), 32'h01);
    check("resync sync_err", 32'(c_se - b_se), 32'h1);
    check("resync no opcode_valid", 32'(c_ov - b_ov), 32'h0);
    check("resync opcode kept", 32'(opcode), 32'h23);
    run_cycle("after_resync", 12'h400, 8'h88, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("resync recover ov", 32'(c_ov - b_ov), 32'h1);
    check("resync recover opcode", 32'(opcode), 32'h88);

    // Missing sync at X3
    snap();
    run_cycle("nosync", 12'h555, 8'hAA, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    check("nosync phase", 32'(phase), 32'h0);
    check("nosync locked", 32'(locked), 32'h0);
    check("nosync sync_err", 32'(c_se - b_se), 32'h1);
    check("nosync step", 32'(c_step - b_step), 32'h8);
    subcycle(1'b0, 4'd0, 4'd0);
    subcycle(1'b0, 4'd0, 4'd0);
    check("idle phase", 32'(phase), 32'h0);
    check("idle step", 32'(c_step - b_step), 32'h8);
    subcycle(1'b1, 4'd0, 4'd0);
    check("relock locked", 32'(locked), 32'h1);
    check("relock phase", 32'(phase), 32'h01);

    // poc_pad during X1
    subcycle(1'b0, 4'h1, 4'd0);
    subcycle(1'b0, 4'h2, 4'd0);
    subcycle(1'b0, 4'h3, 4'd0);
    subcycle(1'b0, 4'hE, 4'd0);
    subcycle(1'b0, 4'h0, 4'b0001);
    check("poc pre io", 32'(io_cycle), 32'h1);
`ifdef MCS4_BUS_SEQ_STATS_EN
    check("poc pre cycle_count", 32'(cycle_count != 16'd0), 32'h1);
`endif
    clk1 = 1'b1;
    tick();
    #2 poc_pad = 1'b1;
    #1;
    check("poc phase", 32'(phase), 32'h0);
    check("poc locked", 32'(locked), 32'h0);
    check("poc addr", 32'(addr), 32'h0);
    check("poc opcode", 32'(opcode), 32'h0);
    check("poc io", 32'(io_cycle), 32'h0);
    check("poc src", 32'({src_addr, src_bank, second_word}), 32'h0);
    check("poc pulses", 32'({step, addr_valid, opcode_valid, src_valid, sync_err}), 32'h0);
`ifdef MCS4_BUS_SEQ_STATS_EN
    check("poc cycle_count", 32'(cycle_count), 32'h0);
`endif
    clk1 = 1'b0;
    tick();
    poc_pad = 1'b0;
    tick();
    subcycle(1'b0, 4'd0, 4'd0);
    check("post poc unsync", 32'(phase), 32'h0);
    subcycle(1'b1, 4'd0, 4'd0);
    check("post poc lock", 32'(locked), 32'h1);
    run_cycle("final", 12'hABC, 8'h5F, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("final addr", 32'(addr), 32'hABC);
    check("final sw", 32'(second_word), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
